// File: rtl/dram_refresh_pkg.sv
// Shared types, default parameters and sizing helper for the DRAM refresh scheduler.
package dram_refresh_pkg;

  typedef enum logic [1:0] {
    INIT_WAIT = 2'd0,
    INIT_REF  = 2'd1,
    RUN       = 2'd2
  } state_t;

  localparam int unsigned DEF_PERIOD      = 375;
  localparam int unsigned DEF_INIT_CYCLES = 5000;
  localparam int unsigned DEF_INIT_REFS   = 8;
  localparam int unsigned DEF_DEBT_MAX    = 7;
  localparam int unsigned DEF_URGENT_TH   = 4;

  // Bits needed to hold values 0..n-1, never less than one.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/ref_tick_timer.sv
// Modulo counter shared by the power-up wait and the refresh interval.
module ref_tick_timer #(
  parameter int unsigned W           = 13,
  parameter int unsigned PERIOD      = 375,
  parameter int unsigned INIT_CYCLES = 5000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic run,
  input  logic sel_init,
  output logic tc
);

  logic [W-1:0] count;
  logic [W-1:0] last;

  always_comb begin
    last = sel_init ? W'(INIT_CYCLES - 1) : W'(PERIOD - 1);
  end

  assign tc = run & (count == last);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (run) begin
      count <= tc ? '0 : count + 1'b1;
    end
  end

endmodule

// File: rtl/dram_refresh_scheduler.sv
// Refresh demand generator: power-up wait, forced init refreshes, then debt-tracked interval refresh.
module dram_refresh_scheduler
  import dram_refresh_pkg::*;
#(
  parameter int unsigned PERIOD      = DEF_PERIOD,
  parameter int unsigned INIT_CYCLES = DEF_INIT_CYCLES,
  parameter int unsigned INIT_REFS   = DEF_INIT_REFS,
  parameter int unsigned DEBT_MAX    = DEF_DEBT_MAX,
  parameter int unsigned URGENT_TH   = DEF_URGENT_TH
) (
  input  logic                                 CLK,
  input  logic                                 nRESET,
  input  logic                                 En,
  input  logic                                 RefAck,
  input  logic                                 ClrLost,
  output logic                                 RefReq,
  output logic                                 RefUrgent,
  output logic                                 InitDone,
  output logic                                 RefLost,
  output logic [cnt_width(DEBT_MAX + 1)-1:0]   Debt
);

  localparam int unsigned DW = cnt_width(DEBT_MAX + 1);
  localparam int unsigned IW = cnt_width(INIT_REFS + 1);
  localparam int unsigned TW = cnt_width((PERIOD > INIT_CYCLES) ? PERIOD : INIT_CYCLES);

  state_t        state;
  logic [DW-1:0] debt;
  logic [IW-1:0] init_cnt;
  logic          ack_prev;
  logic          ack_rise;
  logic          tc;
  logic          tick;
  logic          t_clear;
  logic          t_run;
  logic          t_sel_init;
  logic          set_lost;

  assign ack_rise   = RefAck & ~ack_prev;
  assign t_clear    = (state == INIT_REF);
  assign t_run      = (state == INIT_WAIT) | ((state == RUN) & En);
  assign t_sel_init = (state == INIT_WAIT);
  assign tick       = tc & (state == RUN);
  assign set_lost   = tick & ~ack_rise & (debt == DW'(DEBT_MAX));

  ref_tick_timer #(
    .W           (TW),
    .PERIOD      (PERIOD),
    .INIT_CYCLES (INIT_CYCLES)
  ) u_timer (
    .clk      (CLK),
    .rst_n    (nRESET),
    .clear    (t_clear),
    .run      (t_run),
    .sel_init (t_sel_init),
    .tc       (tc)
  );

  always_ff @(posedge CLK or negedge nRESET) begin
    if (!nRESET) begin
      state    <= INIT_WAIT;
      debt     <= '0;
      init_cnt <= '0;
      ack_prev <= 1'b0;
      RefLost  <= 1'b0;
    end else begin
      ack_prev <= RefAck;

      if (set_lost) begin
        RefLost <= 1'b1;
      end else if (ClrLost) begin
        RefLost <= 1'b0;
      end

      case (state)
        INIT_WAIT: begin
          if (tc) state <= INIT_REF;
        end
        INIT_REF: begin
          if (ack_rise) begin
            init_cnt <= init_cnt + 1'b1;
            if (init_cnt == IW'(INIT_REFS - 1)) begin
              state <= RUN;
              debt  <= '0;
            end
          end
        end
        RUN: begin
          // Tick and ack in the same cycle cancel out.
          if (tick && !ack_rise) begin
            if (debt != DW'(DEBT_MAX)) debt <= debt + 1'b1;
          end else if (ack_rise && !tick && debt != '0) begin
            debt <= debt - 1'b1;
          end
        end
        default: state <= INIT_WAIT;
      endcase
    end
  end

  always_comb begin
    RefReq    = 1'b0;
    RefUrgent = 1'b0;
    InitDone  = 1'b0;
    case (state)
      INIT_REF: begin
        RefReq    = 1'b1;
        RefUrgent = 1'b1;
      end
      RUN: begin
        InitDone  = 1'b1;
        RefReq    = (debt != '0);
        RefUrgent = (debt >= DW'(URGENT_TH));
      end
      default: ;
    endcase
  end

  assign Debt = debt;

endmodule
